// File: rtl/commit_pkg.sv
// Shared encodings and the buffer entry layout seen by the commit stage.
package commit_pkg;

  localparam logic [1:0] S_NOT_USED  = 2'd0;
  localparam logic [1:0] S_EXECUTING = 2'd1;
  localparam logic [1:0] S_EXECUTED  = 2'd2;

  localparam logic [1:0] ALU    = 2'd0;
  localparam logic [1:0] BRANCH = 2'd1;
  localparam logic [1:0] LOAD   = 2'd2;
  localparam logic [1:0] STORE  = 2'd3;

  localparam logic [1:0] BYTE      = 2'd0;
  localparam logic [1:0] HALF_WORD = 2'd1;
  localparam logic [1:0] WORD      = 2'd2;

  typedef struct packed {
    logic [1:0]  e_state;
    logic [1:0]  Unit;
    logic [1:0]  rwmm;
    logic [7:0]  speculative_tag;
    logic [4:0]  Dest;
    logic [31:0] result;
    logic [31:0] A;
    logic [31:0] Vk;
  } entry_t;

endpackage

// File: rtl/commit_unit.sv
// In-order retirement of the two oldest buffer entries: register-file writes,
// committed stores through a req/ack memory handshake, and retired-instruction count.
module commit_unit
  import commit_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  entry_t [1:0]         head,
  output logic   [1:0]         is_really_commited,
  output logic   [1:0]         is_commited_store,
  output logic   [1:0]         rf_we,
  output logic   [1:0][4:0]    rf_addr,
  output logic   [1:0][31:0]   rf_wdata,
  output logic                 mem_req,
  output logic   [31:0]        mem_addr,
  output logic   [31:0]        mem_wdata,
  output logic   [3:0]         mem_wstrb,
  input  logic                 mem_ack,
  output logic [INSTRET_W-1:0] instret
);

  // state | meaning
  // IDLE  | no store in flight; a ready store in head[0] is latched here
  // REQ   | mem_req high with address/data/strobe held until mem_ack
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]  state;
  logic [1:0]  ready;
  logic [1:0]  is_store;
  logic        commit0;
  logic        commit1;
  logic [1:0]  retire_cnt;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ready[k]    = (head[k].e_state == S_EXECUTED) && (head[k].speculative_tag == 8'd0);
      is_store[k] = (head[k].Unit == STORE);
    end
  end

  // A store in slot 0 retires only on the acknowledged REQ cycle; slot 1 never retires a store.
  always_comb begin
    commit0 = is_store[0] ? ((state == REQ) && mem_ack) : ready[0];
    commit1 = commit0 && ready[1] && !is_store[0] && !is_store[1];
    retire_cnt = {1'b0, commit0} + {1'b0, commit1};
  end

  always_comb begin
    is_really_commited = {commit1, commit0};
    is_commited_store  = {1'b0, commit0 && is_store[0]};
    rf_we[0]    = commit0 && !is_store[0] && (head[0].Dest != 5'd0);
    rf_we[1]    = commit1 && (head[1].Dest != 5'd0);
    rf_addr[0]  = head[0].Dest;
    rf_addr[1]  = head[1].Dest;
    rf_wdata[0] = head[0].result;
    rf_wdata[1] = head[1].result;
  end

  // Unknown access sizes still handshake, but write no bytes.
  always_comb begin
    lane_strb = 4'b0000;
    lane_data = head[0].Vk;
    case (head[0].rwmm)
      BYTE: begin
        lane_strb = 4'b0001 << head[0].A[1:0];
        lane_data = {4{head[0].Vk[7:0]}};
      end
      HALF_WORD: begin
        lane_strb = 4'b0011 << {head[0].A[1], 1'b0};
        lane_data = {2{head[0].Vk[15:0]}};
      end
      WORD: begin
        lane_strb = 4'hF;
        lane_data = head[0].Vk;
      end
      default: begin
        lane_strb = 4'b0000;
        lane_data = head[0].Vk;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      instret   <= '0;
    end else begin
      instret <= instret + INSTRET_W'(retire_cnt);
      case (state)
        IDLE: begin
          if (is_store[0] && ready[0]) begin
            mem_addr  <= {head[0].A[31:2], 2'b00};
            mem_wdata <= lane_data;
            mem_wstrb <= lane_strb;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req = (state == REQ);

  logic unused_ok;
  assign unused_ok = ^{head[1].A, head[1].Vk, head[1].rwmm};

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with a narrow retired-instruction counter.
module tb_commit_unit;
  import commit_pkg::*;

  localparam int IW = 4;

  logic            clk;
  logic            reset;
  entry_t [1:0]    head;
  logic [1:0]      is_really_commited;
  logic [1:0]      is_commited_store;
  logic [1:0]      rf_we;
  logic [1:0][4:0] rf_addr;
  logic [1:0][31:0] rf_wdata;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [IW-1:0]   instret;

  int n_checks = 0;
  int n_fail   = 0;

  commit_unit #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .head(head),
    .is_really_commited(is_really_commited), .is_commited_store(is_commited_store),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic entry_t mk(input logic [1:0] st, input logic [1:0] unit,
                                input logic [1:0] sz, input logic [7:0] tag,
                                input logic [4:0] dest, input logic [31:0] res,
                                input logic [31:0] a, input logic [31:0] vk);
    entry_t e;
    e.e_state = st; e.Unit = unit; e.rwmm = sz; e.speculative_tag = tag;
    e.Dest = dest; e.result = res; e.A = a; e.Vk = vk;
    return e;
  endfunction

  initial begin
    reset = 1'b0;
    mem_ack = 1'b0;
    head = '0;
    tick(); tick();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_commit", 64'(is_really_commited), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    reset = 1'b1;

    // two ready ALU ops
    head[0] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd5, 32'h11, 32'd0, 32'd0);
    head[1] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd6, 32'h22, 32'd0, 32'd0);
    #1;
    check("dual_commit", 64'(is_really_commited), 64'b11);
    check("dual_rf_we", 64'(rf_we), 64'b11);
    check("dual_addr0", 64'(rf_addr[0]), 64'd5);
    check("dual_addr1", 64'(rf_addr[1]), 64'd6);
    check("dual_data0", 64'(rf_wdata[0]), 64'h11);
    check("dual_data1", 64'(rf_wdata[1]), 64'h22);
    tick();
    check("dual_instret", 64'(instret), 64'd2);

    // dest 0 in slot 0, slot 1 still executing
    head[0] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd0, 32'h33, 32'd0, 32'd0);
    head[1] = mk(S_EXECUTING, ALU, WORD, 8'd0, 5'd7, 32'h44, 32'd0, 32'd0);
    #1;
    check("single_commit", 64'(is_really_commited), 64'b01);
    check("single_rf_we", 64'(rf_we), 64'b00);
    tick();
    check("single_instret", 64'(instret), 64'd3);

    // a store in slot 1 blocks slot 1
    head[0] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd9, 32'h55, 32'd0, 32'd0);
    head[1] = mk(S_EXECUTED, STORE, WORD, 8'd0, 5'd0, 32'd0, 32'h10, 32'h1);
    #1;
    check("st1_commit", 64'(is_really_commited), 64'b01);
    check("st1_store", 64'(is_commited_store), 64'b00);
    check("st1_rf_we", 64'(rf_we), 64'b01);
    tick();
    check("st1_instret", 64'(instret), 64'd4);

    // byte store, ack in the fourth REQ cycle
    head[0] = mk(S_EXECUTED, STORE, BYTE, 8'd0, 5'd0, 32'd0, 32'h1003, 32'hAB);
    head[1] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd3, 32'h66, 32'd0, 32'd0);
    #1;
    check("sb_idle_commit", 64'(is_really_commited), 64'b00);
    check("sb_idle_req", 64'(mem_req), 64'd0);
    tick();
    check("sb_req", 64'(mem_req), 64'd1);
    check("sb_addr", 64'(mem_addr), 64'h1000);
    check("sb_wstrb", 64'(mem_wstrb), 64'b1000);
    check("sb_wdata", 64'(mem_wdata), 64'hABABABAB);
    check("sb_req1_commit", 64'(is_really_commited), 64'b00);
    tick();
    check("sb_req2", 64'(mem_req), 64'd1);
    check("sb_req2_commit", 64'(is_really_commited), 64'b00);
    tick();
    check("sb_req3_addr", 64'(mem_addr), 64'h1000);
    check("sb_req3_commit", 64'(is_really_commited), 64'b00);
    tick();
    mem_ack = 1'b1;
    #1;
    check("sb_ack_commit", 64'(is_really_commited), 64'b01);
    check("sb_ack_store", 64'(is_commited_store), 64'b01);
    check("sb_ack_rf_we", 64'(rf_we), 64'b00);
    tick();
    mem_ack = 1'b0;
    head = '0;
    check("sb_done_req", 64'(mem_req), 64'd0);
    check("sb_done_instret", 64'(instret), 64'd5);

    // ack without a request is ignored
    mem_ack = 1'b1;
    #1;
    check("stray_ack_commit", 64'(is_really_commited), 64'b00);
    tick();
    check("stray_ack_req", 64'(mem_req), 64'd0);
    check("stray_ack_instret", 64'(instret), 64'd5);
    mem_ack = 1'b0;

    // speculative word store held back until its tag clears
    head[0] = mk(S_EXECUTED, STORE, WORD, 8'h04, 5'd0, 32'd0, 32'h2000, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("spec_no_req", 64'(mem_req), 64'd0);
    end
    head[0].speculative_tag = 8'h00;
    #1;
    check("spec_clear_commit", 64'(is_really_commited), 64'b00);
    tick();
    check("sw_req", 64'(mem_req), 64'd1);
    check("sw_addr", 64'(mem_addr), 64'h2000);
    check("sw_wstrb", 64'(mem_wstrb), 64'hF);
    check("sw_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    mem_ack = 1'b1;
    #1;
    check("sw_ack_commit", 64'(is_really_commited), 64'b01);
    tick();
    mem_ack = 1'b0;
    head = '0;
    check("sw_done_req", 64'(mem_req), 64'd0);
    check("sw_done_instret", 64'(instret), 64'd6);

    // half-word store in the upper lane
    head[0] = mk(S_EXECUTED, STORE, HALF_WORD, 8'd0, 5'd0, 32'd0, 32'h3006, 32'h1234ABCD);
    tick();
    check("sh_addr", 64'(mem_addr), 64'h3004);
    check("sh_wstrb", 64'(mem_wstrb), 64'b1100);
    check("sh_wdata", 64'(mem_wdata), 64'hABCDABCD);
    mem_ack = 1'b1;
    #1;
    check("sh_ack_commit", 64'(is_really_commited), 64'b01);
    tick();
    mem_ack = 1'b0;
    head = '0;
    check("sh_instret", 64'(instret), 64'd7);

    // unknown size: no byte enables, still retires
    head[0] = mk(S_EXECUTED, STORE, 2'd3, 8'd0, 5'd0, 32'd0, 32'h4001, 32'h55);
    tick();
    check("sx_req", 64'(mem_req), 64'd1);
    check("sx_wstrb", 64'(mem_wstrb), 64'd0);
    mem_ack = 1'b1;
    #1;
    check("sx_ack_commit", 64'(is_really_commited), 64'b01);
    tick();
    mem_ack = 1'b0;
    head = '0;
    check("sx_instret", 64'(instret), 64'd8);

    // reset in the second REQ cycle abandons the store
    head[0] = mk(S_EXECUTED, STORE, BYTE, 8'd0, 5'd0, 32'd0, 32'h5000, 32'h1);
    tick();
    check("rq_req1", 64'(mem_req), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rq_req_after_rst", 64'(mem_req), 64'd0);
    check("rq_instret_after_rst", 64'(instret), 64'd0);
    mem_ack = 1'b1;
    #1;
    check("rq_idle_commit", 64'(is_really_commited), 64'b00);
    tick();
    check("rq_relatch_req", 64'(mem_req), 64'd1);
    check("rq_req_commit", 64'(is_really_commited), 64'b01);
    tick();
    mem_ack = 1'b0;
    head = '0;
    check("rq_instret", 64'(instret), 64'd1);

    // counter wrap: 1 + 7*2 = 15, then +2 wraps to 1
    head[0] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd1, 32'h1, 32'd0, 32'd0);
    head[1] = mk(S_EXECUTED, ALU, WORD, 8'd0, 5'd2, 32'h2, 32'd0, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("wrap_all_ones", 64'(instret), 64'hF);
    tick();
    check("wrap_result", 64'(instret), 64'd1);
    head = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage of the out-of-order core, directly downstream of `buffer`. It inspects the two oldest buffer entries (`entries[0]`, `entries[1]`) every cycle and decides how many retire: zero, one or two. For retiring entries it writes results to the architectural register file and performs committed stores through a req/ack data-memory handshake. Its `is_really_commited` and `is_commited_store` outputs drive the `buffer` slide and store-count update.

## Interface
- `INSTRET_W`, default 64: width of the retired-instruction counter.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; when 0 at a rising edge, all state returns to reset values.
- `head`  in  `entry_t` x2: `buffer` `entries[0]` and `entries[1]`; index 0 is the oldest.
- `is_really_commited`  out  `bool` x2: entry retires this cycle (combinational).
- `is_commited_store`  out  `bool` x2: the retiring entry is a store (combinational).
- `rf_we`  out  1 x2: register-file write enables; port 1 is higher priority on equal address.
- `rf_addr`  out  5 x2: destination register.
- `rf_wdata`  out  32 x2: write data, taken from `head[k].result`.
- `mem_req`  out  1: store request (registered).
- `mem_addr`  out  32: word-aligned store address, `{A[31:2],2'b00}` (registered).
- `mem_wdata`  out  32: lane-positioned store data (registered).
- `mem_wstrb`  out  4: byte enables (registered).
- `mem_ack`  in  1: memory accepted the store this cycle.
- `instret`  out  `INSTRET_W`: count of retired instructions.

## Operation
- **ready(k)**: `head[k].e_state == S_EXECUTED` and `head[k].speculative_tag == 0`.
- **Slot 0, non-store**: retires when ready(0).
- **Slot 0, store**: retires only in the cycle `mem_ack` = 1 while the FSM is in REQ.
- **Slot 1**: retires only when all of the following hold:
  - slot 0 retires;
  - ready(1);
  - `head[0].Unit != STORE`;
  - `head[1].Unit != STORE`.
- **Store placement**: at most one store retires per cycle, and a store only ever retires from slot 0.
- **Register write**: for a retiring slot k, `rf_we[k] = (Unit != STORE) && (Dest != 0)`. Otherwise `rf_we[k]` = 0. `rf_addr`/`rf_wdata` are don't-care when `rf_we` = 0.
- **`is_commited_store[k]`** = `is_really_commited[k] && Unit == STORE`.
- **Store FSM, IDLE**:
  - When `head[0]` is a ready store, latch address, data and strobe at the edge and go to REQ.
  - `mem_req` is 0 in IDLE.
- **Store FSM, REQ**:
  - `mem_req` = 1, and `mem_addr`/`mem_wdata`/`mem_wstrb` are held stable.
  - On `mem_ack`, slot 0 retires that cycle and the FSM returns to IDLE.
  - Without `mem_ack`, the FSM stays in REQ indefinitely.
- **Lane formatting**, with `o = A[1:0]` and `d = Vk`:
  - BYTE: `wstrb = 4'b0001 << o`, `wdata = {4{d[7:0]}}`.
  - HALF_WORD: `wstrb = 4'b0011 << {o[1],1'b0}`, `wdata = {2{d[15:0]}}`.
  - WORD: `wstrb = 4'hF`, `wdata = d`.
  - Any other `rwmm` value on a store: `wstrb = 0`. The store still handshakes and retires.
- **`instret`**: increments by the number retired that cycle (0/1/2) and wraps modulo 2^`INSTRET_W`.

## Timing
- **Reset values**:
  - FSM = IDLE; `mem_req` = 0; `mem_addr` = 0; `mem_wdata` = 0; `mem_wstrb` = 0; `instret` = 0.
  - Combinational outputs are 0 whenever the head entries are not ready; `S_NOT_USED` heads are never ready.
- **Non-store latency**: retires in the same cycle `head` shows ready. `buffer` presents the next entries one edge later.
- **Store latency**:
  - First ready cycle: latch.
  - Next cycle: `mem_req` = 1.
  - Retire in the first REQ cycle with `mem_ack` = 1. Minimum is 2 cycles when ack arrives in the first REQ cycle.
- **`mem_ack` with `mem_req` = 0**: ignored.
- **Ack retirement**: `mem_ack` in REQ retires `head[0]` regardless of `head[1]`; slot 1 is blocked that cycle.
- **Reset during REQ**: `mem_req` is 0 after the edge and the pending store is abandoned; `buffer` is reset simultaneously.
- **Speculation**: a store in `head[0]` with a non-zero `speculative_tag` never enters REQ. Once its tag clears, it proceeds normally.
- **`instret` wrap**: at all-ones with 2 retiring, `instret` becomes 1.

## Test plan
- Two ready ALU heads, `Dest` 5 and 6, results 0x11 and 0x22 -> `is_really_commited` = {1,1}; `rf_we` = {1,1}; addresses 5/6 with data 0x11/0x22; `instret` +2.
- `head[0]` ready with `Dest` = 0, `head[1]` `e_state` = `S_EXECUTING` -> only slot 0 retires; `rf_we[0]` = 0; `instret` +1.
- Ready BYTE store, `A` = 0x1003, `Vk` = 0xAB -> next cycle `mem_req` = 1, `mem_addr` = 0x1000, `wstrb` = 0b1000, `wdata` = 0xABABABAB. Ack after 3 REQ cycles -> retires on the ack cycle with `is_commited_store[0]` = 1, then `mem_req` = 0.
- Store in `head[0]` with `speculative_tag` = 0x04 for 5 cycles, then 0 -> no `mem_req` while tagged; normal store sequence afterwards.
- Assert reset (0) in the second REQ cycle -> after the edge `mem_req` = 0, `instret` = 0, FSM = IDLE.
- Preload `instret` to all-ones via 2^`INSTRET_W`-1 retirements (or `INSTRET_W` = 4 build), then retire 2 -> `instret` = 1.
